openframe_pad_cfg_sequencer: RTL and testbench

Staggered pad-configuration controller for the openframe user area. It holds a shadow configuration word for every GPIO pad and accepts writes to that shadow through a valid/ready port. On an apply command it copies changed (dirty) pads to the live configuration outputs one pad at a time, inserting a programmable idle gap after each changed pad so that drive-mode transitions on many pads never switch together. It sits between user control logic and the `gpio_dm*`, `gpio_inp_dis`, `gpio_analog_*` (and related) pad-control outputs of the openframe wrapper.

---
 rtl/openframe_pad_cfg_sequencer.sv | 135 +++++++++++++
 tb/tb_openframe_pad_cfg_sequencer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/openframe_pad_cfg_sequencer.sv
// Staggered pad-configuration sequencer: shadow config writes, then an apply walks all pads and
// copies dirty shadow words to the live outputs one pad at a time with an idle gap after each.
module openframe_pad_cfg_sequencer #(
   parameter int unsigned NUM_PADS  = 44,
   parameter int unsigned GAP_W     = 4,
   parameter logic [10:0] RESET_CFG = 11'h001,
   parameter int unsigned PW        = $clog2(NUM_PADS)
) (
   input  logic                   wb_clk_i,
   input  logic                   wb_rst_i,
   input  logic                   cfg_valid,
   output logic                   cfg_ready,
   input  logic [PW-1:0]          cfg_pad,
   input  logic [10:0]            cfg_data,
   input  logic [GAP_W-1:0]       gap,
   input  logic                   apply_req,
   output logic                   busy,
   output logic                   done,
   output logic [NUM_PADS*11-1:0] pad_cfg
);

   typedef enum logic [1:0] {StIdle, StScan, StGap, StDone} state_e;

   state_e             state_q, state_d;
   logic [PW-1:0]      ptr_q, ptr_d;
   logic [GAP_W-1:0]   gap_q, gap_d;
   logic [GAP_W-1:0]   cnt_q, cnt_d;
   logic [10:0]        shadow_q [NUM_PADS];
   logic [10:0]        live_q   [NUM_PADS];
   logic [NUM_PADS-1:0] dirty_q;

   logic wr_en;
   logic load_en;
   logic advance;
   logic last_pad;

   // Out-of-range pad indices are acknowledged but dropped.
   assign wr_en    = cfg_valid && cfg_ready && ({1'b0, cfg_pad} < (PW+1)'(NUM_PADS));
   assign last_pad = (ptr_q == PW'(NUM_PADS - 1));

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      gap_d   = gap_q;
      cnt_d   = cnt_q;
      load_en = 1'b0;
      advance = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (apply_req) begin
               gap_d   = gap;
               ptr_d   = '0;
               state_d = StScan;
            end
         end
         StScan: begin
            if (dirty_q[ptr_q]) begin
               load_en = 1'b1;
               if (gap_q != '0) begin
                  cnt_d   = gap_q;
                  state_d = StGap;
               end else begin
                  advance = 1'b1;
               end
            end else begin
               advance = 1'b1;
            end
         end
         StGap: begin
            if (cnt_q == GAP_W'(1)) begin
               advance = 1'b1;
            end else begin
               cnt_d = cnt_q - GAP_W'(1);
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
      if (advance) begin
         if (last_pad) begin
            state_d = StDone;
         end else begin
            ptr_d   = ptr_q + PW'(1);
            state_d = StScan;
         end
      end
   end

   assign busy      = (state_q == StScan) || (state_q == StGap);
   assign done      = (state_q == StDone);
   assign cfg_ready = (state_q == StIdle) || (state_q == StDone);

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q <= StIdle;
         ptr_q   <= '0;
         gap_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gap_q   <= gap_d;
         cnt_q   <= cnt_d;
      end
   end

   // Writes only land in IDLE/DONE and loads only in SCAN, so they never collide.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         for (int i = 0; i < NUM_PADS; i++) begin
            shadow_q[i] <= RESET_CFG;
            live_q[i]   <= RESET_CFG;
         end
         dirty_q <= '0;
      end else begin
         if (wr_en) begin
            shadow_q[cfg_pad] <= cfg_data;
            dirty_q[cfg_pad]  <= 1'b1;
         end
         if (load_en) begin
            live_q[ptr_q]  <= shadow_q[ptr_q];
            dirty_q[ptr_q] <= 1'b0;
         end
      end
   end

   for (genvar i = 0; i < NUM_PADS; i++) begin : g_pad_out
      assign pad_cfg[11*i +: 11] = live_q[i];
   end

endmodule

// File: tb/tb_openframe_pad_cfg_sequencer.sv
// Scoreboard bench: stimulus pushes expected pad changes / done pulses, a negedge monitor
// detects them on the DUT outputs and compares in order.
module tb_openframe_pad_cfg_sequencer;

   localparam int NP    = 44;
   localparam int GW    = 4;
   localparam int PWB   = $clog2(NP);
   localparam int VW    = NP * 11;
   localparam logic [VW-1:0] RST_VEC = {NP{11'h001}};

   logic            wb_clk_i = 1'b0;
   logic            wb_rst_i = 1'b1;
   logic            cfg_valid = 1'b0;
   logic            cfg_ready;
   logic [PWB-1:0]  cfg_pad = '0;
   logic [10:0]     cfg_data = '0;
   logic [GW-1:0]   gap = '0;
   logic            apply_req = 1'b0;
   logic            busy;
   logic            done;
   logic [VW-1:0]   pad_cfg;

   openframe_pad_cfg_sequencer #(
      .NUM_PADS (NP),
      .GAP_W    (GW),
      .RESET_CFG(11'h001)
   ) dut (
      .wb_clk_i (wb_clk_i),
      .wb_rst_i (wb_rst_i),
      .cfg_valid(cfg_valid),
      .cfg_ready(cfg_ready),
      .cfg_pad  (cfg_pad),
      .cfg_data (cfg_data),
      .gap      (gap),
      .apply_req(apply_req),
      .busy     (busy),
      .done     (done),
      .pad_cfg  (pad_cfg)
   );

   always #5 wb_clk_i = ~wb_clk_i;

   typedef struct {
      bit          is_done;
      int          pad;
      logic [10:0] val;
      int          cyc;
      int          blen;
   } ev_t;

   ev_t exp_q[$];
   int  n_cmp = 0;
   int  n_err = 0;
   int  cyc   = 0;
   int  base  = 0;

   always @(posedge wb_clk_i) cyc <= cyc + 1;

   task automatic push_pad(input int pad, input logic [10:0] val, input int c);
      ev_t e;
      e.is_done = 1'b0; e.pad = pad; e.val = val; e.cyc = c; e.blen = 0;
      exp_q.push_back(e);
   endtask

   task automatic push_done(input int c, input int blen);
      ev_t e;
      e.is_done = 1'b1; e.pad = 0; e.val = '0; e.cyc = c; e.blen = blen;
      exp_q.push_back(e);
   endtask

   task automatic got_event(input bit is_done, input int pad, input logic [10:0] val,
                            input int c, input int blen);
      ev_t e;
      n_cmp++;
      if (exp_q.size() == 0) begin
         n_err++;
         $display("FAIL unexpected_event: got done=%0d pad %0d=%h cycle %0d busy_len %0d, want none",
                  is_done, pad, val, c, blen);
      end else begin
         e = exp_q.pop_front();
         if (e.is_done != is_done || e.pad != pad || e.val != val || e.cyc != c ||
             e.blen != blen) begin
            n_err++;
            $display("FAIL event: got done=%0d pad %0d=%h cycle %0d busy_len %0d, want done=%0d pad %0d=%h cycle %0d busy_len %0d",
                     is_done, pad, val, c, blen, e.is_done, e.pad, e.val, e.cyc, e.blen);
         end
      end
   endtask

   // Monitor
   logic [VW-1:0] prev;
   int            busy_run = 0;
   always @(negedge wb_clk_i) begin
      int rel;
      if (wb_rst_i) begin
         prev     = pad_cfg;
         busy_run = 0;
      end else begin
         rel = cyc - base + 1;
         for (int k = 0; k < NP; k++) begin
            if (pad_cfg[11*k +: 11] !== prev[11*k +: 11])
               got_event(1'b0, k, pad_cfg[11*k +: 11], rel, 0);
         end
         if (busy) begin
            busy_run++;
            n_cmp++;
            if (cfg_ready !== 1'b0) begin
               n_err++;
               $display("FAIL ready_while_busy: cfg_ready=%b at cycle %0d, want 0", cfg_ready, rel);
            end
         end
         if (done) begin
            n_cmp++;
            if (busy !== 1'b0) begin
               n_err++;
               $display("FAIL busy_in_done: busy=%b at cycle %0d, want 0", busy, rel);
            end
            got_event(1'b1, 0, '0, rel, busy_run);
            busy_run = 0;
         end
         prev = pad_cfg;
      end
   end

   task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] want);
      n_cmp++;
      if (act !== want) begin
         n_err++;
         $display("FAIL %s: got %h, want %h", name, act, want);
      end
   endtask

   // All tasks start and end on a falling edge.
   task automatic write(input int pad, input logic [10:0] data);
      cfg_valid = 1'b1;
      cfg_pad   = PWB'(pad);
      cfg_data  = data;
      @(negedge wb_clk_i);
      cfg_valid = 1'b0;
   endtask

   task automatic apply(input int g);
      gap       = GW'(g);
      apply_req = 1'b1;
      base      = cyc + 1;
      @(negedge wb_clk_i);
      apply_req = 1'b0;
   endtask

   task automatic wait_done();
      bit seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge wb_clk_i);
         if (done) seen = 1'b1;
      end
      if (!seen) begin
         n_cmp++;
         n_err++;
         $display("FAIL done_timeout: got no done within 200 cycles, want done pulse");
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge wb_clk_i);
   endtask

   initial begin
      idle(2);
      wb_rst_i = 1'b0;
      idle(1);

      // Reset state
      check("reset_pad_cfg", pad_cfg, RST_VEC);
      check("reset_busy", VW'(busy), VW'(0));
      check("reset_done", VW'(done), VW'(0));
      check("reset_ready", VW'(cfg_ready), VW'(1));

      // Basic apply, gap=2
      write(3, 11'h006);
      write(40, 11'h402);
      push_pad(3, 11'h006, 5);
      push_pad(40, 11'h402, 44);
      push_done(49, 48);
      apply(2);
      write(5, 11'h3AA);       // refused while busy
      idle(8);
      apply_req = 1'b1;        // ignored while busy
      @(negedge wb_clk_i);
      apply_req = 1'b0;
      wait_done();
      write(9, 11'h055);       // accepted in DONE cycle
      write(50, 11'h7FF);      // out of range, discarded
      idle(4);
      push_pad(9, 11'h055, 11);
      push_done(46, 45);
      apply(1);
      wait_done();
      idle(4);

      // Zero gap with every pad dirty, then an empty scan
      for (int k = 0; k < NP; k++) write(k, 11'h003);
      for (int k = 0; k < NP; k++) push_pad(k, 11'h003, 2 + k);
      push_done(45, 44);
      apply(0);
      wait_done();
      idle(3);
      push_done(45, 44);
      apply(3);
      wait_done();
      idle(3);

      // Overwrite: last write wins, gap=15
      write(7, 11'h001);
      write(7, 11'h7FF);
      push_pad(7, 11'h7FF, 9);
      push_done(60, 59);
      apply(15);
      wait_done();
      idle(3);

      // Rewriting the live value still marks the pad dirty
      write(7, 11'h7FF);
      push_done(47, 46);
      apply(2);
      wait_done();
      idle(3);

      // Reset in the middle of a gap
      write(0, 11'h006);
      push_pad(0, 11'h006, 2);
      apply(5);
      idle(3);
      wb_rst_i = 1'b1;
      #1;
      check("midgap_pad_cfg", pad_cfg, RST_VEC);
      check("midgap_busy", VW'(busy), VW'(0));
      check("midgap_done", VW'(done), VW'(0));
      check("midgap_ready", VW'(cfg_ready), VW'(1));
      idle(2);
      wb_rst_i = 1'b0;
      check("post_reset_ready", VW'(cfg_ready), VW'(1));
      write(2, 11'h123);
      push_pad(2, 11'h123, 4);
      push_done(45, 44);
      apply(0);
      wait_done();
      idle(4);

      while (exp_q.size() != 0) begin
         ev_t e;
         e = exp_q.pop_front();
         n_cmp++;
         n_err++;
         $display("FAIL missing_event: got nothing, want done=%0d pad %0d=%h cycle %0d busy_len %0d",
                  e.is_done, e.pad, e.val, e.cyc, e.blen);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
